// File: rtl/dequant_pkg.sv
// Shared definitions for the 4x4 inverse quantiser: scan table, rescale table,
// position classing, QP clamping and buffer occupancy states.
// No logic of its own; imported by the datapath and control files.
package dequant_pkg;

  // Occupancy of one ping-pong half.
  typedef enum logic [1:0] {
    BUF_EMPTY   = 2'd0,
    BUF_FILLING = 2'd1,
    BUF_FULL    = 2'd2
  } buf_state_t;

  // Rescale class of a coefficient position: A = even/even, B = odd/odd, C = mixed.
  typedef enum logic [1:0] {
    CLS_A = 2'd0,
    CLS_B = 2'd1,
    CLS_C = 2'd2
  } pos_class_t;

  localparam logic [5:0] QP_MAX = 6'd51;

  // Zig-zag scan index -> raster index (row*4+col).
  localparam logic [3:0] ZZ_TO_RASTER [16] = '{
    4'd0, 4'd1, 4'd4, 4'd8, 4'd5, 4'd2, 4'd3, 4'd6,
    4'd9, 4'd12, 4'd13, 4'd10, 4'd7, 4'd11, 4'd14, 4'd15
  };

  // Rescale factors indexed [qp%6][class].
  localparam logic [4:0] V_TAB [6][3] = '{
    '{5'd10, 5'd16, 5'd13},
    '{5'd11, 5'd18, 5'd14},
    '{5'd13, 5'd20, 5'd16},
    '{5'd14, 5'd23, 5'd18},
    '{5'd16, 5'd25, 5'd20},
    '{5'd18, 5'd29, 5'd23}
  };

  // Only the parity of row and column matters for the class.
  function automatic pos_class_t pos_class(input logic row_lsb, input logic col_lsb);
    pos_class_t cls;
    if (!row_lsb && !col_lsb) begin
      cls = CLS_A;
    end else if (row_lsb && col_lsb) begin
      cls = CLS_B;
    end else begin
      cls = CLS_C;
    end
    return cls;
  endfunction

  function automatic logic [5:0] qp_clamp(input logic [5:0] qp);
    return (qp > QP_MAX) ? QP_MAX : qp;
  endfunction

  function automatic logic [3:0] qp_div6(input logic [5:0] qp);
    return 4'(qp / 6'd6);
  endfunction

  function automatic logic [2:0] qp_mod6(input logic [5:0] qp);
    return 3'(qp % 6'd6);
  endfunction

endpackage

// File: rtl/dequant_if.sv
// Level input stream and block output handshake of the inverse quantiser.
// master = producer/consumer side, slave = the quantiser itself.
// Output block is a raster-ordered array of 16 signed coefficients.
interface dequant_if #(
  parameter int BIT_LENGTH = 15,
  parameter int LEVEL_BITS = 12
);
  logic                         in_valid;
  logic                         in_ready;
  logic signed [LEVEL_BITS-1:0] in_level;
  logic [5:0]                   in_qp;
  logic                         out_valid;
  logic                         out_ready;
  logic signed [BIT_LENGTH:0]   out_coeffs [16];

  modport master (
    output in_valid, in_level, in_qp, out_ready,
    input  in_ready, out_valid, out_coeffs
  );

  modport slave (
    input  in_valid, in_level, in_qp, out_ready,
    output in_ready, out_valid, out_coeffs
  );
endinterface

// File: rtl/dequant_scale.sv
// Two-stage rescale: stage 1 registers V lookup and product, stage 2 shifts and saturates.
// Stage-2 result is combinational from stage-1 flops; the caller registers it as the buffer write.
// No backpressure: every accepted level flows through; sideband travels with the data.
module dequant_scale
  import dequant_pkg::*;
#(
  parameter int BIT_LENGTH = 15,
  parameter int LEVEL_BITS = 12
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         s0_vld,
  input  logic signed [LEVEL_BITS-1:0] s0_level,
  input  logic [5:0]                   s0_qp,
  input  logic [3:0]                   s0_idx,
  input  logic                         s0_buf,
  input  logic                         s0_last,
  output logic                         s2_vld,
  output logic [3:0]                   s2_idx,
  output logic                         s2_buf,
  output logic                         s2_last,
  output logic signed [BIT_LENGTH:0]   s2_coeff
);

  localparam int PW = LEVEL_BITS + 6;
  localparam int WW = LEVEL_BITS + 14;

  logic                 vld_q, vld_d;
  logic signed [PW-1:0] prod_q, prod_d;
  logic [3:0]           shift_q, shift_d;
  logic [3:0]           idx_q, idx_d;
  logic                 buf_q, buf_d;
  logic                 last_q, last_d;

  pos_class_t           cls;
  logic [4:0]           vfac;
  logic signed [PW-1:0] lvl_ext;
  logic signed [PW-1:0] v_ext;
  logic signed [WW-1:0] wide;
  logic [WW-1:BIT_LENGTH] wide_hi;

  // Stage 1 next-state: class lookup, V factor, product and shift amount.
  always_comb begin
    cls     = pos_class(s0_idx[2], s0_idx[0]);
    vfac    = V_TAB[qp_mod6(s0_qp)][cls];
    lvl_ext = {{(PW-LEVEL_BITS){s0_level[LEVEL_BITS-1]}}, s0_level};
    v_ext   = {{(PW-5){1'b0}}, vfac};
    prod_d  = lvl_ext * v_ext;
    shift_d = qp_div6(s0_qp);
    vld_d   = s0_vld;
    idx_d   = s0_idx;
    buf_d   = s0_buf;
    last_d  = s0_last;
  end

  // Stage 1 registers; the valid bit is cleared on reset so no stale write escapes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_q   <= 1'b0;
      prod_q  <= '0;
      shift_q <= '0;
      idx_q   <= '0;
      buf_q   <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      vld_q   <= vld_d;
      prod_q  <= prod_d;
      shift_q <= shift_d;
      idx_q   <= idx_d;
      buf_q   <= buf_d;
      last_q  <= last_d;
    end
  end

  // Stage 2: widen, shift by qp/6 and saturate to the output range.
  always_comb begin
    wide    = {{(WW-PW){prod_q[PW-1]}}, prod_q} <<< shift_q;
    wide_hi = wide[WW-1:BIT_LENGTH];
    if ((&wide_hi) || !(|wide_hi)) begin
      s2_coeff = wide[BIT_LENGTH:0];
    end else if (wide[WW-1]) begin
      s2_coeff = {1'b1, {BIT_LENGTH{1'b0}}};
    end else begin
      s2_coeff = {1'b0, {BIT_LENGTH{1'b1}}};
    end
    s2_vld  = vld_q;
    s2_idx  = idx_q;
    s2_buf  = buf_q;
    s2_last = last_q;
  end

endmodule

// File: rtl/dequant_4x4.sv
// Streaming 4x4 inverse quantiser: zig-zag levels in, raster blocks out via ping-pong buffer.
// Latency: out_valid rises 2 cycles after the 16th level fires (when that buffer is next out).
// Backpressure: in_ready drops only while both halves hold complete unread blocks.
module dequant_4x4
  import dequant_pkg::*;
#(
  parameter int BIT_LENGTH = 15,
  parameter int LEVEL_BITS = 12
) (
  input  logic     clk,
  input  logic     reset,
  dequant_if.slave io
);

  logic [3:0]  k_q, k_d;
  logic [5:0]  qp_q, qp_d;
  logic        fill_ptr_q, fill_ptr_d;
  logic        out_ptr_q, out_ptr_d;
  buf_state_t  state_q [2];
  buf_state_t  state_d [2];
  logic signed [BIT_LENGTH:0] buf_q [2][16];
  logic signed [BIT_LENGTH:0] buf_d [2][16];

  logic        in_ready;
  logic        out_valid;
  logic        fire;
  logic        out_fire;
  logic [5:0]  qp_cur;

  logic        wr_vld;
  logic [3:0]  wr_idx;
  logic        wr_buf;
  logic        wr_last;
  logic signed [BIT_LENGTH:0] wr_coeff;

  assign in_ready  = (state_q[fill_ptr_q] != BUF_FULL);
  assign out_valid = (state_q[out_ptr_q] == BUF_FULL);
  assign fire      = io.in_valid && in_ready;
  assign out_fire  = out_valid && io.out_ready;
  assign qp_cur    = (k_q == 4'd0) ? qp_clamp(io.in_qp) : qp_q;

  assign io.in_ready  = in_ready;
  assign io.out_valid = out_valid;

  // Present the output-pointer half; it only changes after an output fire.
  always_comb begin
    for (int i = 0; i < 16; i++) begin
      io.out_coeffs[i] = buf_q[out_ptr_q][i];
    end
  end

  dequant_scale #(
    .BIT_LENGTH (BIT_LENGTH),
    .LEVEL_BITS (LEVEL_BITS)
  ) u_scale (
    .clk      (clk),
    .reset    (reset),
    .s0_vld   (fire),
    .s0_level (io.in_level),
    .s0_qp    (qp_cur),
    .s0_idx   (ZZ_TO_RASTER[k_q]),
    .s0_buf   (fill_ptr_q),
    .s0_last  (k_q == 4'd15),
    .s2_vld   (wr_vld),
    .s2_idx   (wr_idx),
    .s2_buf   (wr_buf),
    .s2_last  (wr_last),
    .s2_coeff (wr_coeff)
  );

  // Scan counter, block QP capture and fill pointer toggle on block wrap.
  always_comb begin
    k_d        = k_q;
    qp_d       = qp_q;
    fill_ptr_d = fill_ptr_q;
    if (fire) begin
      k_d = k_q + 4'd1;
      if (k_q == 4'd0) begin
        qp_d = qp_cur;
      end
      if (k_q == 4'd15) begin
        fill_ptr_d = !fill_ptr_q;
      end
    end
  end

  // Buffer writes from the pipeline and release on output fire; the two never hit the same half.
  always_comb begin
    state_d   = state_q;
    buf_d     = buf_q;
    out_ptr_d = out_ptr_q;
    if (wr_vld) begin
      buf_d[wr_buf][wr_idx] = wr_coeff;
      state_d[wr_buf]       = wr_last ? BUF_FULL : BUF_FILLING;
    end
    if (out_fire) begin
      state_d[out_ptr_q] = BUF_EMPTY;
      out_ptr_d          = !out_ptr_q;
    end
  end

  // Control and buffer state; reset discards any partial or pending block.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      k_q        <= '0;
      qp_q       <= '0;
      fill_ptr_q <= 1'b0;
      out_ptr_q  <= 1'b0;
      for (int b = 0; b < 2; b++) begin
        state_q[b] <= BUF_EMPTY;
        for (int i = 0; i < 16; i++) begin
          buf_q[b][i] <= '0;
        end
      end
    end else begin
      k_q        <= k_d;
      qp_q       <= qp_d;
      fill_ptr_q <= fill_ptr_d;
      out_ptr_q  <= out_ptr_d;
      state_q    <= state_d;
      buf_q      <= buf_d;
    end
  end

endmodule

// File: tb/tb_dequant_4x4.sv
// Self-checking bench for dequant_4x4: directed vectors with literal expectations,
// plus a block-level reference model compared on every cycle a block is presented.
// Random phase streams 1000 blocks with input gaps and output stalls.
module tb_dequant_4x4;

  localparam int BL = 15;
  localparam int LB = 12;
  localparam int MAXC = (1 << BL) - 1;
  localparam int MINC = -(1 << BL);

  localparam int ZZ [16] = '{0, 1, 4, 8, 5, 2, 3, 6, 9, 12, 13, 10, 7, 11, 14, 15};
  localparam int VT [6][3] = '{'{10, 16, 13}, '{11, 18, 14}, '{13, 20, 16},
                               '{14, 23, 18}, '{16, 25, 20}, '{18, 29, 23}};

  typedef int blk_t [16];

  logic clk;
  logic rst;
  dequant_if #(.BIT_LENGTH(BL), .LEVEL_BITS(LB)) io ();

  dequant_4x4 #(.BIT_LENGTH(BL), .LEVEL_BITS(LB)) dut (
    .clk   (clk),
    .reset (rst),
    .io    (io)
  );

  int checks = 0;
  int errors = 0;
  int rdy_mode = 1;   // 0 hold low, 1 hold high, 2 random, 3 driven by main
  blk_t exp_q [$];
  int cur_lvls [16];
  int cur_qp = 0;
  int cur_n = 0;
  int cyc_n = 0;
  int last_fire_cyc = 0;
  int rise_cyc = 0;
  logic prev_ov = 1'b0;
  int n_pop = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic report(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // Reference rescale of one level at one raster position.
  function automatic int exp_coeff(input int lvl, input int qp, input int pos);
    int q, r, c, cls;
    longint v;
    q = (qp > 51) ? 51 : qp;
    r = pos / 4;
    c = pos % 4;
    if ((r % 2 == 0) && (c % 2 == 0)) cls = 0;
    else if ((r % 2 == 1) && (c % 2 == 1)) cls = 1;
    else cls = 2;
    v = longint'(lvl) * longint'(VT[q % 6][cls]) * (longint'(1) << (q / 6));
    if (v > MAXC) v = MAXC;
    if (v < MINC) v = MINC;
    return int'(v);
  endfunction

  // Output ready generator.
  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0: io.out_ready = 1'b0;
      1: io.out_ready = 1'b1;
      2: io.out_ready = ($urandom_range(0, 3) != 0);
      default: ;
    endcase
  end

  // Model + compare: record input fires, check the presented block every valid cycle.
  always @(negedge clk) begin
    blk_t blk;
    int bad;
    cyc_n++;
    if (rst) begin
      cur_n = 0;
      exp_q.delete();
      prev_ov = 1'b0;
    end else begin
      if (io.out_valid) begin
        if (exp_q.size() == 0) begin
          report("out_spurious", 1, 0);
        end else begin
          bad = -1;
          for (int i = 0; i < 16; i++) begin
            if ((int'(io.out_coeffs[i]) != exp_q[0][i]) && (bad < 0)) bad = i;
          end
          if (bad < 0) bad = 0;
          report($sformatf("blk%0d_c%0d", n_pop, bad), int'(io.out_coeffs[bad]), exp_q[0][bad]);
          if (io.out_ready) begin
            void'(exp_q.pop_front());
            n_pop++;
          end
        end
      end
      if (io.out_valid && !prev_ov) rise_cyc = cyc_n;
      prev_ov = io.out_valid;
      if (io.in_valid && io.in_ready) begin
        if (cur_n == 0) cur_qp = int'(io.in_qp);
        cur_lvls[cur_n] = int'(io.in_level);
        if (cur_n == 15) begin
          last_fire_cyc = cyc_n;
          for (int k = 0; k < 16; k++) begin
            blk[ZZ[k]] = exp_coeff(cur_lvls[k], cur_qp, ZZ[k]);
          end
          exp_q.push_back(blk);
          cur_n = 0;
        end else begin
          cur_n++;
        end
      end
    end
  end

  task automatic align();
    @(posedge clk);
    #1;
  endtask

  task automatic push_level(input int lvl, input int qp);
    int n;
    bit rdy;
    io.in_valid = 1'b1;
    io.in_level = 12'(lvl);
    io.in_qp    = 6'(qp);
    n = 0;
    rdy = 1'b0;
    while (!rdy && (n < 500)) begin
      @(negedge clk);
      rdy = io.in_ready;
      @(posedge clk);
      #1;
      n++;
    end
    if (!rdy) report("in_timeout", 0, 1);
    io.in_valid = 1'b0;
  endtask

  task automatic send_block(input int qp, input int lv [16]);
    for (int k = 0; k < 16; k++) push_level(lv[k], qp);
  endtask

  task automatic wait_out_valid(input string name);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!io.out_valid && (n < 100));
    if (!io.out_valid) report(name, 0, 1);
  endtask

  initial begin
    int b [16];
    int nz;
    int pop0;
    int lvl;
    int r;
    int n;

    rst = 1'b1;
    io.in_valid = 1'b0;
    io.in_level = '0;
    io.in_qp = '0;
    io.out_ready = 1'b1;

    // Reset state.
    repeat (2) @(negedge clk);
    report("rst_out_valid", io.out_valid, 0);
    report("rst_in_ready", io.in_ready, 1);
    nz = 0;
    for (int i = 0; i < 16; i++) if (io.out_coeffs[i] != 0) nz++;
    report("rst_coeffs_nonzero", nz, 0);
    align();
    rst = 1'b0;
    align();

    // qp=0, level 1 at k=0.
    b = '{default: 0};
    b[0] = 1;
    send_block(0, b);
    wait_out_valid("t1_timeout");
    report("t1_c0", io.out_coeffs[0], 10);
    report("t1_c5", io.out_coeffs[5], 0);
    align();
    report("t1_latency", rise_cyc - last_fire_cyc, 2);

    // qp=28, class C at raster 1.
    b = '{default: 0};
    b[1] = 1;
    send_block(28, b);
    wait_out_valid("t2_timeout");
    report("t2_c1", io.out_coeffs[1], 320);
    align();

    // qp=28, level -3 at k=4 -> raster 5, class B.
    b = '{default: 0};
    b[4] = -3;
    send_block(28, b);
    wait_out_valid("t3_timeout");
    report("t3_c5", io.out_coeffs[5], -1200);
    align();

    // Saturation at qp=51 and clamped qp=63.
    for (int t = 0; t < 2; t++) begin
      b = '{default: 0};
      b[0] = 2047;
      b[15] = -2048;
      send_block((t == 0) ? 51 : 63, b);
      wait_out_valid("t4_timeout");
      report($sformatf("t4_q%0d_c0", t), io.out_coeffs[0], 32767);
      report($sformatf("t4_q%0d_c15", t), io.out_coeffs[15], -32768);
      align();
    end
    repeat (3) align();

    // Consumer stalled: two blocks accepted, then in_ready falls.
    rdy_mode = 0;
    align();
    b = '{default: 0};
    b[0] = 5;
    send_block(12, b);
    b = '{default: 0};
    b[2] = 7;
    send_block(6, b);
    repeat (3) @(negedge clk);
    report("hold_in_ready", io.in_ready, 0);
    report("hold_out_valid", io.out_valid, 1);
    report("hold_c0", io.out_coeffs[0], 200);
    align();
    rdy_mode = 3;
    io.out_ready = 1'b1;
    @(negedge clk);
    report("pulse_blkA_c0", io.out_coeffs[0], 200);
    align();
    io.out_ready = 1'b0;
    @(negedge clk);
    report("pulse_out_valid", io.out_valid, 1);
    report("pulse_blkB_c4", io.out_coeffs[4], 182);
    report("pulse_in_ready", io.in_ready, 1);
    align();
    rdy_mode = 1;
    repeat (3) align();

    // Reset mid-block with a pending complete block.
    rdy_mode = 0;
    align();
    b = '{default: 0};
    b[0] = 9;
    send_block(20, b);
    for (int k = 0; k < 7; k++) push_level(100 + k, 30);
    @(negedge clk);
    report("prerst_out_valid", io.out_valid, 1);
    align();
    rst = 1'b1;
    @(negedge clk);
    report("midrst_out_valid", io.out_valid, 0);
    report("midrst_in_ready", io.in_ready, 1);
    align();
    rst = 1'b0;
    rdy_mode = 1;
    b = '{default: 0};
    b[3] = -1;
    send_block(18, b);
    wait_out_valid("t6_timeout");
    report("t6_c8", io.out_coeffs[8], -80);
    report("t6_c0", io.out_coeffs[0], 0);
    align();
    repeat (3) align();

    // Random levels, QP, input gaps and output stalls.
    pop0 = n_pop;
    rdy_mode = 2;
    for (int blkn = 0; blkn < 1000; blkn++) begin
      for (int k = 0; k < 16; k++) begin
        if ($urandom_range(0, 9) == 0) repeat ($urandom_range(1, 2)) align();
        r = $urandom_range(0, 9);
        if (r < 3) lvl = 0;
        else if (r == 3) lvl = ($urandom_range(0, 1) != 0) ? 2047 : -2048;
        else if (r < 7) lvl = int'($urandom_range(0, 127)) - 64;
        else lvl = int'($urandom_range(0, 4095)) - 2048;
        push_level(lvl, int'($urandom_range(0, 63)));
      end
    end
    rdy_mode = 1;
    n = 0;
    while ((exp_q.size() != 0) && (n < 200)) begin
      align();
      n++;
    end
    repeat (4) align();
    report("drain_queue", exp_q.size(), 0);
    report("drain_partial", cur_n, 0);
    report("rand_blocks_out", n_pop - pop0, 1000);
    report("drain_out_valid", io.out_valid, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
